// File: rtl/pkt_mc_router_pkg.sv
// Shared constants, default packet width, the stage record layout and the
// masked-key compare used by the multicast router.
package pkt_mc_router_pkg;

    localparam int KEY_BITS     = 32;
    localparam int PKT_BITS     = 72;
    localparam int MAX_CHANNELS = 32;

    typedef struct packed {
        logic [PKT_BITS-1:0]     data;
        logic [MAX_CHANNELS-1:0] route;
        logic                    valid;
    } stage_t;

    function automatic logic key_match(input logic [KEY_BITS-1:0] key,
                                       input logic [KEY_BITS-1:0] entry_key,
                                       input logic [KEY_BITS-1:0] mask);
        return (key & mask) == (entry_key & mask);
    endfunction

endpackage

// File: rtl/pkt_mc_router_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer; on advance the pointer moves just past the granted requester.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] request,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;
    logic          found;
    int            cand;

    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && request[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/pkt_mc_router.sv
// Two-stage multicast packet router: round-robin input selection, masked-key
// table lookup in stage 1, per-channel pending delivery with timeout in stage 2.
module pkt_mc_router
    import pkt_mc_router_pkg::*;
#(
    parameter int PACKET_BITS  = PKT_BITS,
    parameter int NUM_INPUTS   = 4,
    parameter int NUM_CHANNELS = 8,
    parameter int NUM_ENTRIES  = 16,
    parameter int KEY_LSB      = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [KEY_BITS*NUM_ENTRIES-1:0]      reg_key_in,
    input  logic [KEY_BITS*NUM_ENTRIES-1:0]      reg_mask_in,
    input  logic [NUM_CHANNELS*NUM_ENTRIES-1:0]  reg_route_in,
    input  logic [15:0]                          reg_drop_wait_in,
    input  logic [PACKET_BITS*NUM_INPUTS-1:0]    pkt_in_data_in,
    input  logic [NUM_INPUTS-1:0]                pkt_in_vld_in,
    output logic [NUM_INPUTS-1:0]                pkt_in_rdy_out,
    output logic [PACKET_BITS*NUM_CHANNELS-1:0]  pkt_out_data_out,
    output logic [NUM_CHANNELS-1:0]              pkt_out_vld_out,
    input  logic [NUM_CHANNELS-1:0]              pkt_out_rdy_in,
    output logic [31:0]                          miss_cnt_out,
    output logic [31:0]                          drop_cnt_out
);

    logic                    s1_valid;
    logic [PACKET_BITS-1:0]  s1_data;
    logic [PACKET_BITS-1:0]  s2_data;
    logic [NUM_CHANNELS-1:0] pending;
    logic                    s2_valid;
    logic [15:0]             wait_cnt;

    logic [NUM_INPUTS-1:0]   grant;
    logic [PACKET_BITS-1:0]  in_data_sel;
    logic                    accept;
    logic                    s1_free;
    logic                    s1_advance;
    logic                    s1_miss;
    logic                    s2_load;
    logic                    timeout;
    logic                    hit;
    logic [NUM_CHANNELS-1:0] match_route;
    logic [NUM_CHANNELS-1:0] pending_next;

    assign s2_valid = |pending;

    rr_arbiter #(.N(NUM_INPUTS)) u_arbiter (
        .clk     (clk),
        .reset   (reset),
        .request (pkt_in_vld_in),
        .advance (accept),
        .grant   (grant)
    );

    // Lowest-index matching entry wins; an empty route is treated as a miss.
    always_comb begin
        hit         = 1'b0;
        match_route = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (!hit && key_match(s1_data[KEY_LSB +: KEY_BITS],
                                  reg_key_in[e*KEY_BITS +: KEY_BITS],
                                  reg_mask_in[e*KEY_BITS +: KEY_BITS])) begin
                hit         = 1'b1;
                match_route = reg_route_in[e*NUM_CHANNELS +: NUM_CHANNELS];
            end
        end
        s1_miss = (match_route == '0);
    end

    always_comb begin
        timeout      = (reg_drop_wait_in != 16'd0) && s2_valid &&
                       (({1'b0, wait_cnt} + 17'd1) >= {1'b0, reg_drop_wait_in});
        pending_next = timeout ? '0 : (pending & ~pkt_out_rdy_in);
        s2_load      = s1_valid && !s1_miss && (pending_next == '0);
        // Misses leave stage 1 without waiting for stage 2 to drain.
        s1_advance   = s1_valid && (s1_miss || (pending_next == '0));
        s1_free      = !s1_valid || s1_advance;
        pkt_in_rdy_out = (s1_free && !reset) ? grant : '0;
        accept       = s1_free && !reset && (|pkt_in_vld_in);
    end

    always_comb begin
        in_data_sel = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant[i]) begin
                in_data_sel = pkt_in_data_in[i*PACKET_BITS +: PACKET_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_data <= in_data_sel;
        end
        if (s2_load) begin
            s2_data <= s1_data;
        end
    end

    // The wait count restarts with every packet and saturates while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            wait_cnt <= '0;
        end else begin
            pending <= s2_load ? match_route : pending_next;
            if (s2_load || (pending_next == '0)) begin
                wait_cnt <= '0;
            end else if (wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_cnt_out <= '0;
            drop_cnt_out <= '0;
        end else begin
            if (s1_advance && s1_miss && (miss_cnt_out != 32'hFFFF_FFFF)) begin
                miss_cnt_out <= miss_cnt_out + 32'd1;
            end
            if (timeout && (drop_cnt_out != 32'hFFFF_FFFF)) begin
                drop_cnt_out <= drop_cnt_out + 32'd1;
            end
        end
    end

    assign pkt_out_vld_out  = pending;
    assign pkt_out_data_out = {NUM_CHANNELS{s2_data}};

endmodule

// File: tb/tb_pkt_mc_router.sv
// Self-checking bench for pkt_mc_router: directed cases with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_pkt_mc_router;

    localparam int PB = 72;
    localparam int NI = 4;
    localparam int NC = 8;
    localparam int NE = 16;
    localparam int KL = 8;

    logic              clk;
    logic              reset;
    logic [32*NE-1:0]  reg_key;
    logic [32*NE-1:0]  reg_mask;
    logic [NC*NE-1:0]  reg_route;
    logic [15:0]       drop_wait;
    logic [PB*NI-1:0]  pkt_in_data;
    logic [NI-1:0]     pkt_in_vld;
    logic [NI-1:0]     pkt_in_rdy;
    logic [PB*NC-1:0]  pkt_out_data;
    logic [NC-1:0]     pkt_out_vld;
    logic [NC-1:0]     pkt_out_rdy;
    logic [31:0]       miss_cnt;
    logic [31:0]       drop_cnt;

    logic [31:0]       tkey[NE];
    logic [31:0]       tmask[NE];
    logic [NC-1:0]     troute[NE];

    int checks = 0;
    int failures = 0;
    logic run_cmp = 1'b0;

    // Reference state: one packet slot per stage, in packet terms.
    logic          m1_v;
    logic [PB-1:0] m1_d;
    logic [PB-1:0] m2_d;
    logic [NC-1:0] m2_pend;
    int            m2_cnt;
    int            m_last;
    logic [31:0]   m_miss;
    logic [31:0]   m_drop;
    int            took;

    pkt_mc_router #(
        .PACKET_BITS(PB), .NUM_INPUTS(NI), .NUM_CHANNELS(NC),
        .NUM_ENTRIES(NE), .KEY_LSB(KL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .reg_key_in       (reg_key),
        .reg_mask_in      (reg_mask),
        .reg_route_in     (reg_route),
        .reg_drop_wait_in (drop_wait),
        .pkt_in_data_in   (pkt_in_data),
        .pkt_in_vld_in    (pkt_in_vld),
        .pkt_in_rdy_out   (pkt_in_rdy),
        .pkt_out_data_out (pkt_out_data),
        .pkt_out_vld_out  (pkt_out_vld),
        .pkt_out_rdy_in   (pkt_out_rdy),
        .miss_cnt_out     (miss_cnt),
        .drop_cnt_out     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        reg_key   = '0;
        reg_mask  = '0;
        reg_route = '0;
        for (int e = 0; e < NE; e++) begin
            reg_key[e*32 +: 32]   = tkey[e];
            reg_mask[e*32 +: 32]  = tmask[e];
            reg_route[e*NC +: NC] = troute[e];
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PB-1:0] mkPkt(input logic [31:0] key);
        logic [95:0]   r;
        logic [PB-1:0] p;
        r = {$urandom, $urandom, $urandom};
        p = r[PB-1:0];
        p[KL +: 32] = key;
        return p;
    endfunction

    // What the router must present this cycle, from the current packets and inputs.
    function automatic void modelComb(output logic [NI-1:0] rdy_e, output int gidx,
                                      output logic leaves, output logic miss,
                                      output logic [NC-1:0] route, output logic [NC-1:0] pend_after,
                                      output logic to);
        logic [31:0] key;
        bit          hitv;
        bit          s1_free;
        int          i;
        route = '0;
        hitv  = 0;
        key   = m1_d[KL +: 32];
        for (int e = 0; e < NE; e++) begin
            if (!hitv && ((key & tmask[e]) == (tkey[e] & tmask[e]))) begin
                hitv  = 1;
                route = troute[e];
            end
        end
        miss       = (route == '0);
        to         = (drop_wait != 0) && (m2_pend != '0) && (m2_cnt + 1 >= int'(drop_wait));
        pend_after = to ? '0 : (m2_pend & ~pkt_out_rdy);
        leaves     = m1_v && (miss || (pend_after == '0));
        s1_free    = !m1_v || leaves;
        gidx  = -1;
        rdy_e = '0;
        if (s1_free && !reset) begin
            for (int k = 1; k <= NI; k++) begin
                i = (m_last + k) % NI;
                if (gidx < 0 && pkt_in_vld[i]) gidx = i;
            end
        end
        if (gidx >= 0) rdy_e[gidx] = 1'b1;
    endfunction

    always @(posedge clk) begin : model_step
        logic [NI-1:0] r;
        int            g;
        logic          lv, ms, to;
        logic [NC-1:0] rt, pa;
        if (reset) begin
            m1_v <= 1'b0; m2_pend <= '0; m2_cnt <= 0; m_last <= NI - 1;
            m_miss <= '0; m_drop <= '0; took <= -1;
        end else begin
            modelComb(r, g, lv, ms, rt, pa, to);
            if (to && m_drop != 32'hFFFF_FFFF) m_drop <= m_drop + 1;
            if (lv && ms && m_miss != 32'hFFFF_FFFF) m_miss <= m_miss + 1;
            if (lv && !ms) begin
                m2_d <= m1_d; m2_pend <= rt; m2_cnt <= 0;
            end else begin
                m2_pend <= pa;
                m2_cnt  <= (pa != '0) ? m2_cnt + 1 : 0;
            end
            took <= g;
            if (g >= 0) begin
                m1_v <= 1'b1; m1_d <= pkt_in_data[g*PB +: PB]; m_last <= g;
            end else if (lv) begin
                m1_v <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [NI-1:0] r;
        int            g;
        logic          lv, ms, to;
        logic [NC-1:0] rt, pa;
        if (run_cmp && !reset) begin
            modelComb(r, g, lv, ms, rt, pa, to);
            checkOutput("in_rdy", 128'(pkt_in_rdy), 128'(r));
            checkOutput("out_vld", 128'(pkt_out_vld), 128'(m2_pend));
            checkOutput("miss_cnt", 128'(miss_cnt), 128'(m_miss));
            checkOutput("drop_cnt", 128'(drop_cnt), 128'(m_drop));
            for (int c = 0; c < NC; c++) begin
                if (m2_pend[c]) checkOutput("out_data", 128'(pkt_out_data[c*PB +: PB]), 128'(m2_d));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic setDirectedTable();
        for (int e = 0; e < NE; e++) begin
            tkey[e]   = 32'hFFFF_0000 + e;
            tmask[e]  = 32'hFFFF_FFFF;
            troute[e] = NC'(1 << (e % NC));
        end
        tkey[0]   = 32'h0000_0100;
        tmask[0]  = 32'hFFFF_FF00;
        troute[0] = 8'b0000_0101;
    endtask

    task automatic randEntry(input int e);
        int sel;
        sel = int'($urandom_range(3));
        tmask[e]  = (sel == 0) ? 32'hFFFF_FF00 : (sel == 1) ? 32'hFFFF_0000 :
                    (sel == 2) ? 32'hFFFF_FFFF : 32'hFF00_FF00;
        tkey[e]   = $urandom;
        troute[e] = ($urandom_range(5) == 0) ? '0 : NC'($urandom);
    endtask

    function automatic logic [31:0] randKey();
        if ($urandom_range(3) == 0) return $urandom;
        return tkey[$urandom_range(NE - 1)] ^ {24'd0, 8'($urandom)};
    endfunction

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1;
        pkt_in_vld = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Offers one packet and returns at the start of the cycle after its handshake.
    task automatic offerPacket(input int idx, input logic [PB-1:0] p);
        bit done;
        done = 0;
        @(posedge clk); #1;
        pkt_in_vld[idx] = 1'b1;
        pkt_in_data[idx*PB +: PB] = p;
        for (int n = 0; n < 20 && !done; n++) begin
            @(posedge clk); #1;
            if (took == idx) done = 1;
        end
        pkt_in_vld[idx] = 1'b0;
        if (!done) checkOutput("input_handshake_timeout", 128'(0), 128'(1));
    endtask

    task automatic applyStimulus(input int cycles, input int vld_pct, input int rdy_pct);
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                if (!pkt_in_vld[i] || took == i) begin
                    pkt_in_vld[i] = int'($urandom_range(99)) < vld_pct;
                    pkt_in_data[i*PB +: PB] = mkPkt(randKey());
                end
            end
            for (int c = 0; c < NC; c++) pkt_out_rdy[c] = int'($urandom_range(99)) < rdy_pct;
            if ($urandom_range(199) == 0) randEntry(int'($urandom_range(NE - 1)));
            if ($urandom_range(299) == 0) begin
                case ($urandom_range(3))
                    0: drop_wait = 16'd0;
                    1: drop_wait = 16'd1;
                    2: drop_wait = 16'd3;
                    default: drop_wait = 16'd8;
                endcase
            end
        end
    endtask

    initial begin : main
        logic [PB-1:0] p0;
        logic [NC-1:0] exp_vld;
        reset = 1'b1;
        pkt_in_vld = '0;
        pkt_in_data = '0;
        pkt_out_rdy = '1;
        drop_wait = 16'd0;
        setDirectedTable();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_cmp = 1'b1;

        @(negedge clk);
        checkOutput("reset_vld", 128'(pkt_out_vld), 128'(0));
        checkOutput("reset_rdy", 128'(pkt_in_rdy), 128'(0));
        checkOutput("reset_miss", 128'(miss_cnt), 128'(0));
        checkOutput("reset_drop", 128'(drop_cnt), 128'(0));

        // Single multicast packet to channels 0 and 2.
        p0 = mkPkt(32'h0000_01AB);
        @(posedge clk); #1;
        pkt_in_vld[0] = 1'b1;
        pkt_in_data[0 +: PB] = p0;
        @(negedge clk);
        checkOutput("first_grant", 128'(pkt_in_rdy), 128'(4'b0001));
        @(posedge clk); #1;
        pkt_in_vld[0] = 1'b0;
        @(negedge clk);
        checkOutput("latency_cycle1", 128'(pkt_out_vld), 128'(0));
        @(negedge clk);
        checkOutput("latency_cycle2", 128'(pkt_out_vld), 128'(8'b0000_0101));
        checkOutput("mc_data_ch0", 128'(pkt_out_data[0 +: PB]), 128'(p0));
        checkOutput("mc_data_ch2", 128'(pkt_out_data[2*PB +: PB]), 128'(p0));
        @(negedge clk);
        checkOutput("one_beat_only", 128'(pkt_out_vld), 128'(0));

        // Channel 2 stalled five cycles, no timeout.
        doReset();
        pkt_out_rdy = 8'hFB;
        offerPacket(0, mkPkt(32'h0000_0177));
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            pkt_out_rdy = (k >= 6) ? 8'hFF : 8'hFB;
            @(negedge clk);
            exp_vld = (k == 1) ? 8'h05 : (k <= 6) ? 8'h04 : 8'h00;
            checkOutput("stall_vld", 128'(pkt_out_vld), 128'(exp_vld));
        end
        checkOutput("stall_no_drop", 128'(drop_cnt), 128'(0));

        // Channel 2 held off, dropped after ten busy cycles.
        doReset();
        drop_wait = 16'd10;
        pkt_out_rdy = 8'hFB;
        offerPacket(0, mkPkt(32'h0000_0100));
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            exp_vld = (k == 1) ? 8'h05 : (k <= 10) ? 8'h04 : 8'h00;
            checkOutput("timeout_vld", 128'(pkt_out_vld), 128'(exp_vld));
        end
        checkOutput("timeout_drop_cnt", 128'(drop_cnt), 128'(1));

        // Unmatched key.
        doReset();
        drop_wait = 16'd0;
        pkt_out_rdy = 8'hFF;
        offerPacket(0, mkPkt(32'hDEAD_BEEF));
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("miss_no_vld", 128'(pkt_out_vld), 128'(0));
        end
        checkOutput("miss_cnt_one", 128'(miss_cnt), 128'(1));

        // Overlapping entries 3 and 7, then reset while stage 2 is busy.
        @(posedge clk); #1;
        tkey[3] = 32'h0000_3300; tmask[3] = 32'hFFFF_FF00; troute[3] = 8'h30;
        tkey[7] = 32'h0000_3000; tmask[7] = 32'hFFFF_F000; troute[7] = 8'hC0;
        pkt_out_rdy = 8'h0F;
        offerPacket(1, mkPkt(32'h0000_33AA));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("lowest_entry_route", 128'(pkt_out_vld), 128'(8'h30));
        checkOutput("miss_cnt_kept", 128'(miss_cnt), 128'(1));
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_vld", 128'(pkt_out_vld), 128'(0));
        checkOutput("async_reset_miss", 128'(miss_cnt), 128'(0));
        checkOutput("async_reset_drop", 128'(drop_cnt), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        pkt_out_rdy = 8'hFF;
        setDirectedTable();

        // All inputs valid continuously: strict rotation, one packet per cycle out.
        @(posedge clk); #1;
        pkt_in_vld = '1;
        for (int i = 0; i < NI; i++) pkt_in_data[i*PB +: PB] = mkPkt(32'h0000_01AB);
        for (int j = 0; j < 7; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            checkOutput("rr_grant", 128'(pkt_in_rdy), 128'(4'b0001 << (j % 4)));
            checkOutput("rr_throughput", 128'(pkt_out_vld), 128'((j >= 2) ? 8'h05 : 8'h00));
        end
        @(posedge clk); #1;
        pkt_in_vld = '0;

        // Randomized traffic with a random, occasionally rewritten table.
        doReset();
        for (int e = 0; e < NE; e++) randEntry(e);
        applyStimulus(1500, 60, 70);
        applyStimulus(800, 90, 95);
        drop_wait = 16'd3;
        applyStimulus(600, 40, 30);
        @(posedge clk); #1;
        pkt_in_vld = '0;
        pkt_out_rdy = '1;
        repeat (20) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
